// File: rtl/pipe_scoreboard.sv
// Hazard-detection and forwarding-select scoreboard beside the ID stage.
// Tracks {valid, write-back, load, dest} for each post-ID stage (1 = EX).
module pipe_scoreboard #(
    parameter int unsigned STAGES = 3,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned SELW  = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              branch_taken,
    input  logic              freeze,
    output logic              hazard,
    output logic [SELW-1:0]   fwd_sel1,
    output logic [SELW-1:0]   fwd_sel2,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [STAGES:1]   v_q, v_d;
    logic [STAGES:1]   wb_q, wb_d;
    logic [STAGES:1]   ld_q, ld_d;
    logic [REG_AW-1:0] dest_q [STAGES:1];
    logic [REG_AW-1:0] dest_d [STAGES:1];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [STAGES:1]   match1, match2;
    logic              issue;

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int s = 1; s <= STAGES; s++) begin
            match1[s] = id_valid & v_q[s] & wb_q[s] & (dest_q[s] == id_src1);
            match2[s] = id_valid & id_two_src & v_q[s] & wb_q[s] & (dest_q[s] == id_src2);
        end
    end

    always_comb begin
        hazard   = 1'b0;
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        if (FWD_EN != 0) begin
            // Only a load still in EX cannot be forwarded in time.
            hazard = ld_q[1] & (match1[1] | match2[1]);
            if (!hazard) begin
                // Walk oldest to youngest so the youngest writer wins.
                for (int s = STAGES; s >= 1; s--) begin
                    if (match1[s]) fwd_sel1 = SELW'(s);
                    if (match2[s]) fwd_sel2 = SELW'(s);
                end
            end
        end else begin
            hazard = |{match1, match2};
        end
    end

    always_comb begin
        v_d    = v_q;
        wb_d   = wb_q;
        ld_d   = ld_q;
        dest_d = dest_q;
        cnt_d  = cnt_q;
        issue  = id_valid & ~hazard & ~branch_taken;
        if (!freeze) begin
            for (int s = STAGES; s >= 2; s--) begin
                v_d[s]    = v_q[s-1];
                wb_d[s]   = wb_q[s-1];
                ld_d[s]   = ld_q[s-1];
                dest_d[s] = dest_q[s-1];
            end
            v_d[1]    = issue;
            wb_d[1]   = issue & id_wb_en;
            ld_d[1]   = issue & id_mem_r_en;
            dest_d[1] = issue ? id_dest : '0;
            if (hazard && !branch_taken && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q    <= '0;
            wb_q   <= '0;
            ld_q   <= '0;
            dest_q <= '{default: '0};
            cnt_q  <= '0;
        end else begin
            v_q    <= v_d;
            wb_q   <= wb_d;
            ld_q   <= ld_d;
            dest_q <= dest_d;
            cnt_q  <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Bench for pipe_scoreboard: a forwarding instance and a stall-only CNT_W=4 instance
// share stimulus; directed vector table, corner sequences and a random run vs. a model.
module tb_pipe_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid, id_two_src, id_wb_en, id_mem_r_en, branch_taken, freeze;
    logic [3:0] id_src1, id_src2, id_dest;

    logic        hz_a, hz_b;
    logic [1:0]  s1_a, s2_a, s1_b, s2_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_scoreboard #(.STAGES(3), .REG_AW(4), .FWD_EN(1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .id_dest(id_dest), .branch_taken(branch_taken), .freeze(freeze),
        .hazard(hz_a), .fwd_sel1(s1_a), .fwd_sel2(s2_a), .stall_cnt(cnt_a)
    );

    pipe_scoreboard #(.STAGES(3), .REG_AW(4), .FWD_EN(0), .CNT_W(4)) u_stl (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .id_dest(id_dest), .branch_taken(branch_taken), .freeze(freeze),
        .hazard(hz_b), .fwd_sel1(s1_b), .fwd_sel2(s2_b), .stall_cnt(cnt_b)
    );

    // Reference model: d=0 forwarding instance, d=1 stall-only instance.
    bit         mv  [2][1:3];
    bit         mwb [2][1:3];
    bit         mld [2][1:3];
    logic [3:0] mdest [2][1:3];
    int         mcnt [2];

    function automatic int youngest(int d, logic [3:0] src, logic gate);
        for (int s = 1; s <= 3; s++)
            if (gate && id_valid && mv[d][s] && mwb[d][s] && mdest[d][s] == src) return s;
        return 0;
    endfunction

    function automatic bit m_hz(int d);
        int y1 = youngest(d, id_src1, 1'b1);
        int y2 = youngest(d, id_src2, id_two_src);
        if (d == 1) return (y1 != 0) || (y2 != 0);
        return mld[d][1] && (y1 == 1 || y2 == 1);
    endfunction

    function automatic int m_sel(int d, int y);
        return (d == 1 || m_hz(d)) ? 0 : y;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0;
            for (int s = 1; s <= 3; s++) begin
                mv[d][s] = 0; mwb[d][s] = 0; mld[d][s] = 0; mdest[d][s] = 4'd0;
            end
        end
    endtask

    task automatic model_advance();
        bit hz [2];
        bit issue;
        for (int d = 0; d < 2; d++) hz[d] = m_hz(d);
        if (rst && !freeze) begin
            for (int d = 0; d < 2; d++) begin
                for (int s = 3; s >= 2; s--) begin
                    mv[d][s] = mv[d][s-1]; mwb[d][s] = mwb[d][s-1];
                    mld[d][s] = mld[d][s-1]; mdest[d][s] = mdest[d][s-1];
                end
                issue = id_valid && !hz[d] && !branch_taken;
                mv[d][1]    = issue;
                mwb[d][1]   = issue && id_wb_en;
                mld[d][1]   = issue && id_mem_r_en;
                mdest[d][1] = issue ? id_dest : 4'd0;
                if (hz[d] && !branch_taken && mcnt[d] < ((d == 0) ? 65535 : 15)) mcnt[d]++;
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input int v, input int s1, input int s2, input int two, input int wb,
                         input int ld, input int dst, input int br, input int frz);
        id_valid = v[0]; id_src1 = s1[3:0]; id_src2 = s2[3:0]; id_two_src = two[0];
        id_wb_en = wb[0]; id_mem_r_en = ld[0]; id_dest = dst[3:0];
        branch_taken = br[0]; freeze = frz[0];
    endtask

    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " hz_a"}, int'(hz_a), int'(m_hz(0)));
        chk({tag, " sel1_a"}, int'(s1_a), m_sel(0, youngest(0, id_src1, 1'b1)));
        chk({tag, " sel2_a"}, int'(s2_a), m_sel(0, youngest(0, id_src2, id_two_src)));
        chk({tag, " cnt_a"}, int'(cnt_a), mcnt[0]);
        chk({tag, " hz_b"}, int'(hz_b), int'(m_hz(1)));
        chk({tag, " sel1_b"}, int'(s1_b), 0);
        chk({tag, " sel2_b"}, int'(s2_b), 0);
        chk({tag, " cnt_b"}, int'(cnt_b), mcnt[1]);
    endtask

    typedef struct {
        int v, s1, s2, two, wb, ld, dst, br;
        int hz, sel1, sel2, cnt;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // v, s1, s2, two, wb, ld, dst, br | hazard, sel1, sel2, cnt  (forwarding instance)
        tbl[0]  = '{1, 0, 0, 0, 1, 0, 2, 0,  0, 0, 0, 0};  // ADD R2
        tbl[1]  = '{1, 2, 3, 1, 1, 0, 6, 0,  0, 1, 0, 0};  // SUB R6 <- R2 (EX fwd)
        tbl[2]  = '{1, 2, 6, 1, 0, 0, 0, 0,  0, 2, 1, 0};  // reads R2 (MEM), R6 (EX)
        tbl[3]  = '{1, 9, 0, 0, 1, 1, 4, 0,  0, 0, 0, 0};  // LDR R4
        tbl[4]  = '{1, 1, 4, 1, 1, 0, 5, 0,  1, 0, 0, 0};  // load-use on src2
        tbl[5]  = '{1, 1, 4, 1, 1, 0, 5, 0,  0, 0, 2, 1};  // retry after bubble
        tbl[6]  = '{0, 5, 5, 1, 0, 0, 0, 0,  0, 0, 0, 1};  // id_valid low: no match
        tbl[7]  = '{1, 5, 0, 0, 0, 0, 0, 0,  0, 2, 0, 1};
        tbl[8]  = '{1, 5, 5, 0, 0, 0, 0, 0,  0, 3, 0, 1};  // src2 gated by two_src
        tbl[9]  = '{1, 3, 0, 0, 1, 1, 5, 1,  0, 0, 0, 1};  // flushed LDR R5
        tbl[10] = '{1, 5, 5, 1, 0, 0, 0, 0,  0, 0, 0, 1};  // R5 not in flight

        do_reset();
        chk("reset hz_a", int'(hz_a), 0);
        chk("reset cnt_a", int'(cnt_a), 0);
        chk("reset cnt_b", int'(cnt_b), 0);

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].s1, tbl[i].s2, tbl[i].two, tbl[i].wb, tbl[i].ld,
                  tbl[i].dst, tbl[i].br, 0);
            #1;
            chk($sformatf("tbl%0d hazard", i), int'(hz_a), tbl[i].hz);
            chk($sformatf("tbl%0d sel1", i), int'(s1_a), tbl[i].sel1);
            chk($sformatf("tbl%0d sel2", i), int'(s2_a), tbl[i].sel2);
            chk($sformatf("tbl%0d cnt", i), int'(cnt_a), tbl[i].cnt);
            step();
        end

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            id_valid     = ($urandom_range(0, 9) < 8);
            id_src1      = 4'($urandom_range(0, 3));
            id_src2      = 4'($urandom_range(0, 3));
            id_two_src   = 1'($urandom_range(0, 1));
            id_wb_en     = ($urandom_range(0, 3) != 0);
            id_mem_r_en  = ($urandom_range(0, 2) == 0);
            id_dest      = 4'($urandom_range(0, 3));
            branch_taken = ($urandom_range(0, 9) == 0);
            freeze       = ($urandom_range(0, 6) == 0);
            #1;
            check_model($sformatf("rnd%0d", i));
            step();
        end

        // Asynchronous reset with three valid entries in flight.
        do_reset();
        drive(1, 0, 0, 0, 1, 1, 1, 0, 0); step();
        drive(1, 1, 0, 0, 1, 0, 2, 0, 0); step(); step();
        drive(1, 0, 0, 0, 1, 0, 3, 0, 0); step();
        drive(1, 0, 0, 0, 1, 0, 7, 0, 0); step();
        drive(1, 3, 2, 1, 0, 0, 0, 0, 0);
        #1;
        chk("prerst sel1_a", int'(s1_a), 2);
        chk("prerst sel2_a", int'(s2_a), 3);
        chk("prerst cnt_a", int'(cnt_a), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst hz_a", int'(hz_a), 0);
        chk("arst sel1_a", int'(s1_a), 0);
        chk("arst sel2_a", int'(s2_a), 0);
        chk("arst cnt_a", int'(cnt_a), 0);
        chk("arst hz_b", int'(hz_b), 0);
        chk("arst cnt_b", int'(cnt_b), 0);
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;

        // Stall-only: dependency on EX stalls three cycles.
        do_reset();
        drive(1, 0, 0, 0, 1, 0, 1, 0, 0); step();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stl%0d hz_b", i), int'(hz_b), 1);
            chk($sformatf("stl%0d sel1_b", i), int'(s1_b), 0);
            step();
        end
        chk("stl done hz_b", int'(hz_b), 0);
        chk("stl done cnt_b", int'(cnt_b), 3);

        // Freeze holds a pending load-use; branch is ignored while frozen.
        do_reset();
        drive(1, 0, 0, 0, 1, 1, 4, 0, 0); step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 4, 1, 0, 0, 0, (i >= 2) ? 1 : 0, 1);
            #1;
            chk($sformatf("frz%0d hz_a", i), int'(hz_a), 1);
            chk($sformatf("frz%0d cnt_a", i), int'(cnt_a), 0);
            step();
        end
        drive(1, 0, 4, 1, 0, 0, 0, 0, 0);
        #1;
        chk("unfrz hz_a", int'(hz_a), 1);
        step();
        chk("unfrz cnt_a", int'(cnt_a), 1);
        chk("unfrz hz_a after", int'(hz_a), 0);
        chk("unfrz sel2_a", int'(s2_a), 2);

        // Saturation of the 4-bit stall counter.
        do_reset();
        drive(1, 1, 0, 0, 1, 0, 1, 0, 0);
        repeat (8) step();
        chk("sat mid cnt_b", int'(cnt_b), 6);
        repeat (22) step();
        chk("sat cnt_b", int'(cnt_b), 15);
        chk("sat cnt_a", int'(cnt_a), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised hazard-detection and forwarding-select unit for the ARM pipeline. It sits beside the ID stage and replaces the hard-tied `hazard = 0` path. It tracks the destination register, write-back enable and load flag of every instruction in flight across `STAGES` post-ID stages. From these it produces the ID stall, per-source forwarding selects and a saturating stall counter, and it honours branch flush and memory freeze.

## Interface
- `STAGES`, 3, number of tracked post-ID stages (1 = EX … STAGES = WB); range 1–7
- `REG_AW`, 4, register-index width
- `FWD_EN`, 1, 1 = forwarding enabled, 0 = stall-only mode
- `CNT_W`, 16, stall-counter width
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  ID holds a real instruction
- `id_src1`, `id_src2`  in  REG_AW  ID source registers (Rn, Rm/Rd)
- `id_two_src`  in  1  `id_src2` is actually read
- `id_wb_en`, `id_mem_r_en`  in  1  ID instruction writes back / is a load
- `id_dest`  in  REG_AW  ID destination register
- `branch_taken`  in  1  flush request from EX
- `freeze`  in  1  memory stall; the whole pipeline holds
- `hazard`  out  1  stall IF/ID; insert bubble into EX
- `fwd_sel1`, `fwd_sel2`  out  SELW=$clog2(STAGES+1)  0 = register file, s = forward from stage s
- `stall_cnt`  out  CNT_W  cycles stalled by hazard

## Operation
- Scoreboard: `STAGES` entries {v, wb, ld, dest}, entry s mirrors pipeline stage s.
- Match for source x in stage s: `id_valid & v[s] & wb[s] & (dest[s] == src_x)`. The src2 match is additionally gated by `id_two_src`. R0 is a real register and is not special.
- FWD_EN=0:
  - `hazard` = any match in any stage.
  - `fwd_sel*` = 0 always.
- FWD_EN=1:
  - `hazard` = match in stage 1 with `ld[1]=1` (load-use).
  - `fwd_selx` = lowest (youngest) matching s, else 0.
  - When `hazard=1`, `fwd_sel*` is don't-care and is driven to 0.
- Advance on each rising edge with `freeze=0`:
  - Entries s = 2..STAGES take entry s-1.
  - Entry 1 takes {id_valid, id_wb_en, id_mem_r_en, id_dest} when `id_valid & !hazard & !branch_taken`. Otherwise entry 1 takes a bubble (v=0, wb=0, ld=0, dest=0).
- `freeze=1`: every entry holds; `stall_cnt` holds; `branch_taken` is ignored that cycle. EX holds too, so the flush is re-presented after the freeze.
- Priority: reset > freeze > branch_taken > hazard.
- `stall_cnt` increments on each edge with `hazard & !freeze & !branch_taken`. It saturates at 2^CNT_W−1 and never wraps.
- `hazard` and `fwd_sel*` are combinational from the entries and the ID inputs. Counter and entries are registered.

## Timing
- Reset (`rst`=0, asynchronous): all entries cleared (v=0), `stall_cnt`=0. Consequently `hazard`=0 and `fwd_sel*`=0 while ID inputs are idle.
- Deassertion is synchronous to `clk` (external synchronizer).
- Reset mid-operation clears all in-flight state immediately, without waiting for an edge.
- Stall latency:
  - Load-use inserts exactly 1 bubble (FWD_EN=1).
  - In stall-only mode, a dependency on stage s stalls for STAGES−s+1 cycles.
- A new entry is visible to the match logic the cycle after the edge that loads it.
- Flush squashes only the ID instruction. Older entries continue to shift.

## Test plan
- Reset: drive `rst`=0 mid-stream with 3 valid entries → `hazard`=0, `fwd_sel1`=`fwd_sel2`=0 and `stall_cnt`=0 without a clock edge.
- Forwarding, FWD_EN=1, STAGES=3: issue ADD R2←…, then SUB using R2 as src1 → `fwd_sel1`=1 and `hazard`=0. One cycle later, with a non-dependent instruction between them → `fwd_sel1`=2.
- Load-use: LDR R4, then ADD reading R4 with `id_two_src`=1 as src2 → `hazard`=1 for one cycle and `stall_cnt`=1. The next cycle gives `hazard`=0 and `fwd_sel2`=2.
- Stall-only, FWD_EN=0, STAGES=3: MOV R1, then dependent instruction → `hazard` high for 3 consecutive cycles, `stall_cnt`=3, `fwd_sel*` always 0.
- Flush and freeze:
  - `branch_taken`=1 while ID holds a load to R5 → next cycle entry 1 is a bubble, and a reader of R5 sees `hazard`=0 and `fwd_sel`=0.
  - `freeze`=1 for 4 cycles with a pending load-use → `hazard` stays 1, entries hold and `stall_cnt` stays unchanged.
- Saturation, CNT_W=4: hold a stall-only dependency across repeated issues for 20 stall cycles → `stall_cnt` stops at 15.
